commit_trace_unit: RTL and testbench

//  Producer side of the commit trace. Sits in cpu next to the writeback stage and takes
//  one retire event per cycle. Classifies each event and stamps it with an instruction

---
 rtl/trace_pkg.sv | 37 +++
 rtl/trace_fifo.sv | 55 +++++
 rtl/commit_trace_unit.sv | 169 ++++++++++++++++
 tb/tb_commit_trace_unit.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared definitions for the commit trace unit: record kinds, FSM states and
// the packed trace record. Optional build macro: TRACE_CYCLE_STAMP_EN adds a
// 32-bit cycle stamp field to every record.
package trace_pkg;

    // Record classification written into trc_kind
    typedef enum logic [2:0] {
        TRC_NOP   = 3'd0,
        TRC_REG   = 3'd1,
        TRC_LOAD  = 3'd2,
        TRC_STORE = 3'd3,
        TRC_HALT  = 3'd4
    } trc_kind_e;

    // Producer FSM: accept retires, drain after HALT, then park
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } trc_state_e;

    // One trace record as stored in the FIFO
    typedef struct packed {
`ifdef TRACE_CYCLE_STAMP_EN
        logic [31:0] cycle;
`endif
        trc_kind_e   kind;
        logic [31:0] inum;
        logic [15:0] pc;
        logic [3:0]  rg;
        logic [15:0] data;
        logic [15:0] addr;
    } trc_rec_t;

    localparam int TRC_REC_W = $bits(trc_rec_t);

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO holding trace records. Caller guarantees push only when
// not full (or popping the same cycle) and pop only when not empty.
// Read data is the head entry taken straight from the storage registers.
module trace_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    // Storage array: written only on push, no reset needed (head is gated by empty)
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leaves count unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/commit_trace_unit.sv
// Commit trace producer: classifies retire events, stamps them with an
// instruction number, queues them and offers them on a valid/ready port.
// Optional build macro: TRACE_CYCLE_STAMP_EN (free-running cycle stamp and
// trc_cycle output).
// Handshake: a record transfers on any cycle where trc_valid && trc_ready;
// while trc_valid=1 and trc_ready=0 all trc_* outputs hold steady.
module commit_trace_unit
    import trace_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int AFULL_MARGIN = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ret_valid,
    input  logic [15:0] ret_pc,
    input  logic        ret_reg_we,
    input  logic [3:0]  ret_reg,
    input  logic [15:0] ret_reg_data,
    input  logic        ret_mem_re,
    input  logic        ret_mem_we,
    input  logic [15:0] ret_mem_addr,
    input  logic [15:0] ret_mem_data,
    input  logic        ret_hlt,
    output logic        trc_valid,
    input  logic        trc_ready,
    output logic [2:0]  trc_kind,
    output logic [31:0] trc_inum,
    output logic [15:0] trc_pc,
    output logic [3:0]  trc_reg,
    output logic [15:0] trc_data,
    output logic [15:0] trc_addr,
`ifdef TRACE_CYCLE_STAMP_EN
    output logic [31:0] trc_cycle,
`endif
    output logic        stall_req,
    output logic        overflow,
    output logic        halted,
    output logic [1:0]  o_dbg_state
);

    localparam int CW = $clog2(DEPTH) + 1;

    trc_state_e             r_state;
    logic [31:0]            r_inum;
    logic                   r_overflow;
    logic                   r_halted;
    trc_rec_t               w_rec;
    trc_rec_t               w_head;
    trc_rec_t               w_out;
    logic [TRC_REC_W-1:0]   w_head_bits;
    logic                   w_push_req;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic [CW-1:0]          w_count;

`ifdef TRACE_CYCLE_STAMP_EN
    logic [31:0]            r_cycle;

    // Free-running cycle counter sampled into each pushed record
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cycle <= '0;
        else        r_cycle <= r_cycle + 32'd1;
    end
`endif

    // Classify the retire event and build its record (priority LOAD, REG, HALT, STORE, NOP)
    always_comb begin
        w_rec      = '0;
        w_rec.inum = r_inum;
        w_rec.pc   = ret_pc;
`ifdef TRACE_CYCLE_STAMP_EN
        w_rec.cycle = r_cycle;
`endif
        if (ret_reg_we && ret_mem_re) begin
            w_rec.kind = TRC_LOAD;
            w_rec.rg   = ret_reg;
            w_rec.data = ret_reg_data;
            w_rec.addr = ret_mem_addr;
        end else if (ret_reg_we) begin
            w_rec.kind = TRC_REG;
            w_rec.rg   = ret_reg;
            w_rec.data = ret_reg_data;
        end else if (ret_hlt) begin
            w_rec.kind = TRC_HALT;
        end else if (ret_mem_we) begin
            w_rec.kind = TRC_STORE;
            w_rec.data = ret_mem_data;
            w_rec.addr = ret_mem_addr;
        end else begin
            w_rec.kind = TRC_NOP;
        end
    end

    // A full FIFO still accepts a push when the head is leaving the same cycle
    assign w_push_req = ret_valid && (r_state == ST_RUN);
    assign w_pop      = trc_ready && !w_empty;
    assign w_push     = w_push_req && (!w_full || w_pop);

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (TRC_REC_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (w_rec),
        .i_pop   (w_pop),
        .o_rdata (w_head_bits),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // INUM advances on every retire seen in RUN, dropped or not, so gaps show up
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inum     <= '0;
            r_overflow <= 1'b0;
        end else if (w_push_req) begin
            r_inum <= r_inum + 32'd1;
            if (w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    // FSM: HALT accepted -> DRAIN; HALT record consumed -> DONE (sticky until reset)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_push && (w_rec.kind == TRC_HALT)) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (w_pop && (w_head.kind == TRC_HALT)) begin
                        r_state  <= ST_DONE;
                        r_halted <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_DONE;
                end
            endcase
        end
    end

    assign w_head = trc_rec_t'(w_head_bits);
    assign w_out  = w_empty ? trc_rec_t'('0) : w_head;

    assign trc_valid   = !w_empty;
    assign trc_kind    = w_out.kind;
    assign trc_inum    = w_out.inum;
    assign trc_pc      = w_out.pc;
    assign trc_reg     = w_out.rg;
    assign trc_data    = w_out.data;
    assign trc_addr    = w_out.addr;
`ifdef TRACE_CYCLE_STAMP_EN
    assign trc_cycle   = w_out.cycle;
`endif
    assign stall_req   = (w_count >= CW'(DEPTH - AFULL_MARGIN));
    assign overflow    = r_overflow;
    assign halted      = r_halted;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_commit_trace_unit.sv
// Bench for commit_trace_unit: directed scenarios plus a randomized phase,
// checked against a queue-based reference model of the trace behaviour.
module tb_commit_trace_unit;
    import trace_pkg::*;

    localparam int DEPTH = 8;
    localparam int AFULL = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ret_valid = 1'b0;
    logic [15:0] ret_pc = '0;
    logic        ret_reg_we = 1'b0;
    logic [3:0]  ret_reg = '0;
    logic [15:0] ret_reg_data = '0;
    logic        ret_mem_re = 1'b0;
    logic        ret_mem_we = 1'b0;
    logic [15:0] ret_mem_addr = '0;
    logic [15:0] ret_mem_data = '0;
    logic        ret_hlt = 1'b0;
    logic        trc_valid;
    logic        trc_ready = 1'b0;
    logic [2:0]  trc_kind;
    logic [31:0] trc_inum;
    logic [15:0] trc_pc;
    logic [3:0]  trc_reg;
    logic [15:0] trc_data;
    logic [15:0] trc_addr;
`ifdef TRACE_CYCLE_STAMP_EN
    logic [31:0] trc_cycle;
`endif
    logic        stall_req;
    logic        overflow;
    logic        halted;
    logic [1:0]  dbg_state;

    commit_trace_unit #(.DEPTH(DEPTH), .AFULL_MARGIN(2)) dut (
        .clk(clk), .rst_n(rst_n), .ret_valid(ret_valid), .ret_pc(ret_pc),
        .ret_reg_we(ret_reg_we), .ret_reg(ret_reg), .ret_reg_data(ret_reg_data),
        .ret_mem_re(ret_mem_re), .ret_mem_we(ret_mem_we), .ret_mem_addr(ret_mem_addr),
        .ret_mem_data(ret_mem_data), .ret_hlt(ret_hlt), .trc_valid(trc_valid),
        .trc_ready(trc_ready), .trc_kind(trc_kind), .trc_inum(trc_inum), .trc_pc(trc_pc),
        .trc_reg(trc_reg), .trc_data(trc_data), .trc_addr(trc_addr),
`ifdef TRACE_CYCLE_STAMP_EN
        .trc_cycle(trc_cycle),
`endif
        .stall_req(stall_req), .overflow(overflow), .halted(halted), .o_dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Reference model state
    typedef struct packed {
        logic [2:0]  kind;
        logic [31:0] inum;
        logic [15:0] pc;
        logic [3:0]  rg;
        logic [15:0] data;
        logic [15:0] addr;
    } rec_t;

    rec_t        mq[$];
    logic [31:0] m_inum;
    bit          m_ovf, m_drain, m_done;
    int          n_total = 0;
    int          n_pass  = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        assert (act === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    // Record the specification's rules would produce for the current retire inputs
    function automatic rec_t build();
        rec_t r;
        r = '0;
        r.inum = m_inum;
        r.pc   = ret_pc;
        if (ret_reg_we && ret_mem_re) begin
            r.kind = 3'd2; r.rg = ret_reg; r.data = ret_reg_data; r.addr = ret_mem_addr;
        end else if (ret_reg_we) begin
            r.kind = 3'd1; r.rg = ret_reg; r.data = ret_reg_data;
        end else if (ret_hlt) begin
            r.kind = 3'd4;
        end else if (ret_mem_we) begin
            r.kind = 3'd3; r.data = ret_mem_data; r.addr = ret_mem_addr;
        end else begin
            r.kind = 3'd0;
        end
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_inum  = '0;
        m_ovf   = 1'b0;
        m_drain = 1'b0;
        m_done  = 1'b0;
    endtask

    task automatic model_step();
        bit   pop, push;
        rec_t r;
        pop  = trc_ready && (mq.size() > 0);
        push = ret_valid && !m_drain && !m_done;
        r    = build();
        if (pop) begin
            if (mq[0].kind == 3'd4) m_done = 1'b1;
            void'(mq.pop_front());
        end
        if (push) begin
            if (mq.size() < DEPTH) begin
                mq.push_back(r);
                if (r.kind == 3'd4) m_drain = 1'b1;
            end else begin
                m_ovf = 1'b1;
            end
            m_inum = m_inum + 32'd1;
        end
    endtask

    task automatic check_outputs();
        logic [1:0] exp_st;
        exp_st = m_done ? ST_DONE : (m_drain ? ST_DRAIN : ST_RUN);
        chk("valid", 32'(trc_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("kind", 32'(trc_kind), 32'(mq[0].kind));
            chk("inum", trc_inum, mq[0].inum);
            chk("pc",   32'(trc_pc),   32'(mq[0].pc));
            chk("reg",  32'(trc_reg),  32'(mq[0].rg));
            chk("data", 32'(trc_data), 32'(mq[0].data));
            chk("addr", 32'(trc_addr), 32'(mq[0].addr));
        end
        chk("stall_req", 32'(stall_req), 32'(mq.size() >= AFULL));
        chk("overflow",  32'(overflow),  32'(m_ovf));
        chk("halted",    32'(halted),    32'(m_done));
        chk("state",     32'(dbg_state), 32'(exp_st));
    endtask

    // One clock: check at negedge, advance model, step through posedge
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        ret_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_valid", 32'(trc_valid), 32'd0);
        chk("rst_kind",  32'(trc_kind),  32'd0);
        chk("rst_inum",  trc_inum,       32'd0);
        chk("rst_pc",    32'(trc_pc),    32'd0);
        chk("rst_reg",   32'(trc_reg),   32'd0);
        chk("rst_data",  32'(trc_data),  32'd0);
        chk("rst_addr",  32'(trc_addr),  32'd0);
        chk("rst_stall", 32'(stall_req), 32'd0);
        chk("rst_ovf",   32'(overflow),  32'd0);
        chk("rst_halt",  32'(halted),    32'd0);
        chk("rst_state", 32'(dbg_state), 32'(ST_RUN));
        @(posedge clk);
        #1;
    endtask

    // Drive one retire: k 0=NOP 1=REG 2=LOAD 3=STORE 4=HALT 5=random flags (no HALT)
    task automatic set_ret(input int k);
        ret_valid    = 1'b1;
        ret_pc       = 16'($urandom);
        ret_reg      = 4'($urandom);
        ret_reg_data = 16'($urandom);
        ret_mem_addr = 16'($urandom);
        ret_mem_data = 16'($urandom);
        ret_reg_we   = (k == 1) || (k == 2);
        ret_mem_re   = (k == 2);
        ret_mem_we   = (k == 3);
        ret_hlt      = (k == 4);
        if (k == 5) begin
            ret_reg_we = 1'($urandom);
            ret_mem_re = 1'($urandom);
            ret_mem_we = 1'($urandom);
        end
    endtask

    initial begin
        model_reset();

        // 1: single REG retire
        do_reset();
        trc_ready = 1'b1;
        set_ret(1);
        ret_reg = 4'd3; ret_reg_data = 16'h00AB; ret_pc = 16'h0002;
        cycle();
        ret_valid = 1'b0;
        chk("t1_valid", 32'(trc_valid), 32'd1);
        chk("t1_kind",  32'(trc_kind),  32'd1);
        chk("t1_inum",  trc_inum,       32'd0);
        chk("t1_reg",   32'(trc_reg),   32'd3);
        chk("t1_data",  32'(trc_data),  32'h00AB);
        cycle();
        cycle();

        // 2: LOAD then STORE
        do_reset();
        trc_ready = 1'b0;
        set_ret(2);
        ret_reg = 4'd1; ret_mem_addr = 16'h0010; ret_reg_data = 16'h1234;
        cycle();
        set_ret(3);
        ret_mem_addr = 16'h0020; ret_mem_data = 16'h5555;
        cycle();
        ret_valid = 1'b0;
        chk("t2_kind0", 32'(trc_kind), 32'd2);
        chk("t2_addr0", 32'(trc_addr), 32'h0010);
        trc_ready = 1'b1;
        cycle();
        chk("t2_kind1", 32'(trc_kind), 32'd3);
        chk("t2_inum1", trc_inum,      32'd1);
        chk("t2_data1", 32'(trc_data), 32'h5555);
        repeat (2) cycle();

        // 3: fill, stall, overflow, drain, INUM gap
        do_reset();
        trc_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            set_ret($urandom_range(0, 3));
            cycle();
        end
        ret_valid = 1'b0;
        chk("t3_ovf",   32'(overflow),  32'd1);
        chk("t3_stall", 32'(stall_req), 32'd1);
        trc_ready = 1'b1;
        repeat (8) cycle();
        set_ret(1);
        cycle();
        ret_valid = 1'b0;
        chk("t3_inum_gap", trc_inum, 32'd9);
        repeat (2) cycle();

        // 4: HALT followed by ignored retires
        do_reset();
        trc_ready = 1'b0;
        set_ret(4);
        ret_pc = 16'h0040;
        cycle();
        for (int i = 0; i < 3; i++) begin
            set_ret(1);
            cycle();
        end
        ret_valid = 1'b0;
        chk("t4_kind", 32'(trc_kind), 32'd4);
        chk("t4_pc",   32'(trc_pc),   32'h0040);
        trc_ready = 1'b1;
        cycle();
        chk("t4_halted", 32'(halted),    32'd1);
        chk("t4_valid",  32'(trc_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            set_ret(1);
            cycle();
        end
        ret_valid = 1'b0;

        // 5: push and pop together on a full FIFO
        do_reset();
        trc_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            set_ret(5);
            cycle();
        end
        trc_ready = 1'b1;
        set_ret(1);
        cycle();
        ret_valid = 1'b0;
        chk("t5_ovf",   32'(overflow),  32'd0);
        chk("t5_stall", 32'(stall_req), 32'd1);
        repeat (DEPTH + 1) cycle();

        // 6: async reset in the middle of a drain
        do_reset();
        trc_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_ret(1);
            cycle();
        end
        ret_valid = 1'b0;
        trc_ready = 1'b1;
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_valid_async", 32'(trc_valid), 32'd0);
        chk("t6_stall_async", 32'(stall_req), 32'd0);
        do_reset();
        set_ret(1);
        cycle();
        ret_valid = 1'b0;
        chk("t6_inum",  trc_inum,       32'd0);
        chk("t6_state", 32'(dbg_state), 32'(ST_RUN));
        cycle();

        // Random traffic with varying consumer throughput
        do_reset();
        for (int blk = 0; blk < 8; blk++) begin
            int rdy_pct;
            rdy_pct = $urandom_range(10, 100);
            for (int i = 0; i < 40; i++) begin
                trc_ready = ($urandom_range(1, 100) <= rdy_pct);
                if ($urandom_range(0, 3) != 0) set_ret($urandom_range(0, 5));
                else ret_valid = 1'b0;
                cycle();
            end
        end
        ret_valid = 1'b0;
        trc_ready = 1'b1;
        repeat (DEPTH + 2) cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
